// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target that exposes a bank of 8-bit registers.
// The first data byte of a write sets the register pointer; later bytes are
// written through a one-cycle strobe. Reads stream bytes from the pointer.
// The pointer auto-increments after every byte and wraps at NUM_REGS.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   scl_in, sda_in    raw open-drain pad values
//   scl_oe, sda_oe    1 = pull the line low
//   wr_en/addr/data   register write strobe, index and byte
//   rd_addr, rd_data  register read index and combinational read data
//   busy              high between START and STOP
//
// Build option: define I2C_CLOCK_STRETCH_EN to hold SCL low for
// STRETCH_CYCLES clocks at the end of every ACK/CACK bit.
module i2c_target_regs #(
   parameter logic [6:0]  ADDRESS        = 7'h42,
   parameter int unsigned NUM_REGS       = 16,
   parameter int unsigned STRETCH_CYCLES = 4,
   localparam int unsigned PTR_W         = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             scl_in,
   input  logic             sda_in,
   output logic             scl_oe,
   output logic             sda_oe,
   output logic             wr_en,
   output logic [PTR_W-1:0] wr_addr,
   output logic [7:0]       wr_data,
   output logic [PTR_W-1:0] rd_addr,
   input  logic [7:0]       rd_data,
   output logic             busy
);

   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_ADDR       = 4'd1;
   localparam logic [3:0] S_ADDR_ACK   = 4'd2;
   localparam logic [3:0] S_PTR        = 4'd3;
   localparam logic [3:0] S_PTR_ACK    = 4'd4;
   localparam logic [3:0] S_WDATA      = 4'd5;
   localparam logic [3:0] S_WDATA_ACK  = 4'd6;
   localparam logic [3:0] S_RDATA      = 4'd7;
   localparam logic [3:0] S_RDATA_CACK = 4'd8;

   // Pad synchronisers plus one delayed copy for edge detection
   logic r_scl_m, r_scl_s, r_scl_q;
   logic r_sda_m, r_sda_s, r_sda_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_scl_m <= 1'b1; r_scl_s <= 1'b1; r_scl_q <= 1'b1;
         r_sda_m <= 1'b1; r_sda_s <= 1'b1; r_sda_q <= 1'b1;
      end else begin
         r_scl_m <= scl_in; r_scl_s <= r_scl_m; r_scl_q <= r_scl_s;
         r_sda_m <= sda_in; r_sda_s <= r_sda_m; r_sda_q <= r_sda_s;
      end
   end

   logic w_scl_rise, w_scl_fall, w_start, w_stop;
   assign w_scl_rise = r_scl_s & ~r_scl_q;
   assign w_scl_fall = ~r_scl_s & r_scl_q;
   assign w_start    = r_scl_s & r_scl_q & r_sda_q & ~r_sda_s;
   assign w_stop     = r_scl_s & r_scl_q & ~r_sda_q & r_sda_s;

   logic [3:0]       r_state,   w_state_nxt;
   logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
   logic [6:0]       r_shift,   w_shift_nxt;
   logic [PTR_W-1:0] r_ptr,     w_ptr_nxt;
   logic             r_sda_oe,  w_sda_oe_nxt;
   logic             r_wr_en,   w_wr_en_nxt;
   logic [PTR_W-1:0] r_wr_addr, w_wr_addr_nxt;
   logic [7:0]       r_wr_data, w_wr_data_nxt;
   logic             r_busy,    w_busy_nxt;
   logic             r_rw,      w_rw_nxt;
   logic             r_cack_ok, w_cack_ok_nxt;
   logic             w_ack_end, w_proceed;
   logic [7:0]       w_byte;

   // Byte completed by the bit sampled on the current SCL rise
   assign w_byte = {r_shift, r_sda_s};

`ifdef I2C_CLOCK_STRETCH_EN
   localparam int unsigned STR_W = $clog2(STRETCH_CYCLES + 1);
   logic             r_scl_oe,  w_scl_oe_nxt;
   logic             r_str_act, w_str_act_nxt;
   logic [STR_W-1:0] r_str_cnt, w_str_cnt_nxt;
`endif

   // Next-state and datapath logic
   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_nxt   = r_shift;
      w_ptr_nxt     = r_ptr;
      w_sda_oe_nxt  = r_sda_oe;
      w_wr_en_nxt   = 1'b0;
      w_wr_addr_nxt = r_wr_addr;
      w_wr_data_nxt = r_wr_data;
      w_busy_nxt    = r_busy;
      w_rw_nxt      = r_rw;
      w_cack_ok_nxt = r_cack_ok;
      w_ack_end     = 1'b0;
      w_proceed     = 1'b0;
`ifdef I2C_CLOCK_STRETCH_EN
      w_scl_oe_nxt  = r_scl_oe;
      w_str_act_nxt = r_str_act;
      w_str_cnt_nxt = r_str_cnt;
`endif
      if (w_start) begin
         w_state_nxt   = S_ADDR;
         w_bit_cnt_nxt = 3'd0;
         w_sda_oe_nxt  = 1'b0;
         w_busy_nxt    = 1'b1;
         w_cack_ok_nxt = 1'b0;
`ifdef I2C_CLOCK_STRETCH_EN
         w_scl_oe_nxt  = 1'b0;
         w_str_act_nxt = 1'b0;
`endif
      end else if (w_stop) begin
         w_state_nxt  = S_IDLE;
         w_sda_oe_nxt = 1'b0;
         w_busy_nxt   = 1'b0;
`ifdef I2C_CLOCK_STRETCH_EN
         w_scl_oe_nxt  = 1'b0;
         w_str_act_nxt = 1'b0;
`endif
      end
`ifdef I2C_CLOCK_STRETCH_EN
      // SCL is held low by us here, so no bus edges need handling
      else if (r_str_act) begin
         if (r_str_cnt == '0) begin
            w_scl_oe_nxt  = 1'b0;
            w_str_act_nxt = 1'b0;
            w_proceed     = 1'b1;
         end else begin
            w_str_cnt_nxt = r_str_cnt - STR_W'(1);
         end
      end
`endif
      else begin
         case (r_state)
            S_ADDR, S_PTR, S_WDATA: begin
               if (w_scl_rise) begin
                  w_shift_nxt   = w_byte[6:0];
                  w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) begin
                     if (r_state == S_ADDR) begin
                        if (w_byte[7:1] == ADDRESS) begin
                           w_state_nxt = S_ADDR_ACK;
                           w_rw_nxt    = w_byte[0];
                        end else begin
                           w_state_nxt = S_IDLE;
                        end
                     end else if (r_state == S_PTR) begin
                        w_ptr_nxt   = w_byte[PTR_W-1:0];
                        w_state_nxt = S_PTR_ACK;
                     end else begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = r_ptr;
                        w_wr_data_nxt = w_byte;
                        w_state_nxt   = S_WDATA_ACK;
                     end
                  end
               end
            end
            // First fall drives ACK, second fall (end of 9th bit) releases it
            S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
               if (w_scl_fall) begin
                  if (!r_sda_oe) w_sda_oe_nxt = 1'b1;
                  else           w_ack_end    = 1'b1;
               end
            end
            S_RDATA: begin
               if (w_scl_fall) begin
                  if (r_bit_cnt == 3'd7) begin
                     w_sda_oe_nxt  = 1'b0;
                     w_state_nxt   = S_RDATA_CACK;
                     w_cack_ok_nxt = 1'b0;
                  end else begin
                     w_sda_oe_nxt  = ~r_shift[6];
                     w_shift_nxt   = {r_shift[5:0], 1'b0};
                     w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                  end
               end
            end
            // Pointer advances on the ACK rise so rd_data is ready at the fall
            S_RDATA_CACK: begin
               if (w_scl_rise) begin
                  if (!r_sda_s) begin
                     w_cack_ok_nxt = 1'b1;
                     w_ptr_nxt     = r_ptr + PTR_W'(1);
                  end else begin
                     w_state_nxt = S_IDLE;
                  end
               end else if (w_scl_fall && r_cack_ok) begin
                  w_ack_end = 1'b1;
               end
            end
            default: ;
         endcase
         if (w_ack_end) begin
            w_sda_oe_nxt = 1'b0;
`ifdef I2C_CLOCK_STRETCH_EN
            w_scl_oe_nxt  = 1'b1;
            w_str_act_nxt = 1'b1;
            w_str_cnt_nxt = STR_W'(STRETCH_CYCLES - 1);
`else
            w_proceed = 1'b1;
`endif
         end
      end
      // Leave an ACK/CACK bit and start the following byte
      if (w_proceed) begin
         w_bit_cnt_nxt = 3'd0;
         if ((r_state == S_RDATA_CACK) || ((r_state == S_ADDR_ACK) && r_rw)) begin
            w_state_nxt  = S_RDATA;
            w_shift_nxt  = rd_data[6:0];
            w_sda_oe_nxt = ~rd_data[7];
         end else if (r_state == S_ADDR_ACK) begin
            w_state_nxt = S_PTR;
         end else begin
            w_state_nxt = S_WDATA;
            if (r_state == S_WDATA_ACK) w_ptr_nxt = r_ptr + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= 3'd0;
         r_shift   <= 7'd0;
         r_ptr     <= '0;
         r_sda_oe  <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= 8'd0;
         r_busy    <= 1'b0;
         r_rw      <= 1'b0;
         r_cack_ok <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_shift   <= w_shift_nxt;
         r_ptr     <= w_ptr_nxt;
         r_sda_oe  <= w_sda_oe_nxt;
         r_wr_en   <= w_wr_en_nxt;
         r_wr_addr <= w_wr_addr_nxt;
         r_wr_data <= w_wr_data_nxt;
         r_busy    <= w_busy_nxt;
         r_rw      <= w_rw_nxt;
         r_cack_ok <= w_cack_ok_nxt;
      end
   end

`ifdef I2C_CLOCK_STRETCH_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         r_scl_oe  <= 1'b0;
         r_str_act <= 1'b0;
         r_str_cnt <= '0;
      end else begin
         r_scl_oe  <= w_scl_oe_nxt;
         r_str_act <= w_str_act_nxt;
         r_str_cnt <= w_str_cnt_nxt;
      end
   end
   assign scl_oe = r_scl_oe;
`else
   logic w_unused_stretch;
   assign w_unused_stretch = 1'(STRETCH_CYCLES);
   assign scl_oe = 1'b0;
`endif

   assign sda_oe  = r_sda_oe;
   assign wr_en   = r_wr_en;
   assign wr_addr = r_wr_addr;
   assign wr_data = r_wr_data;
   assign rd_addr = r_ptr;
   assign busy    = r_busy;

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: directed bench for i2c_target_regs. A bit-level I2C
// controller model drives an open-drain bus; register writes and clock
// stretch pulses are logged by negedge monitors and compared to hand values.
`timescale 1ns/1ps
module tb_i2c_target_regs;

   localparam int Q = 16;   // quarter SCL period in clk cycles

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       scl_in, sda_in, scl_oe, sda_oe, wr_en, busy;
   logic [3:0] wr_addr, rd_addr;
   logic [7:0] wr_data, rd_data;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   assign scl_in  = m_scl & ~scl_oe;
   assign sda_in  = m_sda & ~sda_oe;
   assign rd_data = 8'h10 + 8'(rd_addr);

   i2c_target_regs dut (
      .clk     (clk),
      .reset   (reset),
      .scl_in  (scl_in),
      .sda_in  (sda_in),
      .scl_oe  (scl_oe),
      .sda_oe  (sda_oe),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .busy    (busy)
   );

   // Write log, SDA-drive counter and SCL hold-low pulse lengths
   logic [3:0] q_wa[$];
   logic [7:0] q_wd[$];
   int         sda_cnt = 0;
   int         str_len = 0;
   int         str_q[$];

   always @(negedge clk) begin
      if (wr_en) begin
         q_wa.push_back(wr_addr);
         q_wd.push_back(wr_data);
      end
      if (sda_oe) sda_cnt++;
      if (scl_oe) str_len++;
      else if (str_len != 0) begin
         str_q.push_back(str_len);
         str_len = 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic wcyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Release SCL and wait (bounded) for a stretching target to let go
   task automatic scl_hi();
      int t;
      t = 0;
      m_scl = 1'b1;
      while (scl_in !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("scl_release", 32'(scl_in), 32'd1);
   endtask

   task automatic send_bit(input logic b);
      m_sda = b;
      wcyc(Q);
      scl_hi();
      wcyc(2*Q);
      m_scl = 1'b0;
      wcyc(Q);
   endtask

   task automatic get_bit(output logic b);
      m_sda = 1'b1;
      wcyc(Q);
      scl_hi();
      wcyc(Q);
      b = sda_in;
      wcyc(Q);
      m_scl = 1'b0;
      wcyc(Q);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1;
      wcyc(Q);
      scl_hi();
      wcyc(Q);
      m_sda = 1'b0;
      wcyc(Q);
      m_scl = 1'b0;
      wcyc(Q);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0;
      wcyc(Q);
      scl_hi();
      wcyc(Q);
      m_sda = 1'b1;
      wcyc(Q);
   endtask

   task automatic send_bits(input logic [7:0] v, input int n);
      for (int i = 7; i > 7 - n; i--) send_bit(v[i]);
   endtask

   task automatic send_byte(input logic [7:0] v, output logic ack);
      logic b;
      send_bits(v, 8);
      get_bit(b);
      ack = ~b;
   endtask

   task automatic recv_byte(output logic [7:0] d, input logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         get_bit(b);
         d[i] = b;
      end
      send_bit(~ack);
   endtask

   initial begin
      logic       ack;
      logic [7:0] d;
      int         n0;
      int         s0;

      // Reset values
      wcyc(3);
      chk("rst_sda_oe",  32'(sda_oe),  32'd0);
      chk("rst_scl_oe",  32'(scl_oe),  32'd0);
      chk("rst_wr_en",   32'(wr_en),   32'd0);
      chk("rst_busy",    32'(busy),    32'd0);
      chk("rst_rd_addr", 32'(rd_addr), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      reset = 1'b0;
      wcyc(4);

      // Write pointer 3, data A5 and 5A
      n0 = q_wa.size();
      i2c_start();
      chk("wr_busy", 32'(busy), 32'd1);
      send_byte(8'h84, ack); chk("wr_addr_ack", 32'(ack), 32'd1);
      send_byte(8'h03, ack); chk("wr_ptr_ack",  32'(ack), 32'd1);
      chk("wr_ptr_load", 32'(rd_addr), 32'd3);
      send_byte(8'hA5, ack); chk("wr_d0_ack", 32'(ack), 32'd1);
      send_byte(8'h5A, ack); chk("wr_d1_ack", 32'(ack), 32'd1);
      i2c_stop();
      wcyc(4);
      chk("wr_busy_clr", 32'(busy), 32'd0);
      chk("wr_count", 32'(q_wa.size() - n0), 32'd2);
      if (q_wa.size() >= n0 + 2) begin
         chk("wr0_addr", 32'(q_wa[n0]),   32'd3);
         chk("wr0_data", 32'(q_wd[n0]),   32'hA5);
         chk("wr1_addr", 32'(q_wa[n0+1]), 32'd4);
         chk("wr1_data", 32'(q_wd[n0+1]), 32'h5A);
      end
      chk("wr_ptr_end", 32'(rd_addr), 32'd5);

      // Pointer 0F, repeated START, read two bytes across the wrap
      n0 = q_wa.size();
      i2c_start();
      send_byte(8'h84, ack); chk("rd_waddr_ack", 32'(ack), 32'd1);
      send_byte(8'h0F, ack); chk("rd_ptr_ack",   32'(ack), 32'd1);
      i2c_start();
      send_byte(8'h85, ack); chk("rd_raddr_ack", 32'(ack), 32'd1);
      recv_byte(d, 1'b1);    chk("rd_byte0", 32'(d), 32'h1F);
      recv_byte(d, 1'b0);    chk("rd_byte1", 32'(d), 32'h10);
      chk("rd_nack_sda", 32'(sda_oe), 32'd0);
      chk("rd_ptr_wrap", 32'(rd_addr), 32'd0);
      i2c_stop();
      wcyc(4);
      chk("rd_busy_clr", 32'(busy), 32'd0);
      chk("rd_no_wr", 32'(q_wa.size() - n0), 32'd0);

      // Address mismatch: target stays silent
      n0 = q_wa.size();
      s0 = sda_cnt;
      i2c_start();
      send_byte(8'h86, ack); chk("mis_addr_nack", 32'(ack), 32'd0);
      chk("mis_busy", 32'(busy), 32'd1);
      send_byte(8'h55, ack); chk("mis_data_nack", 32'(ack), 32'd0);
      i2c_stop();
      wcyc(4);
      chk("mis_busy_clr", 32'(busy), 32'd0);
      chk("mis_sda_quiet", 32'(sda_cnt - s0), 32'd0);
      chk("mis_no_wr", 32'(q_wa.size() - n0), 32'd0);

      // Reset during the 5th data bit of a write
      n0 = q_wa.size();
      i2c_start();
      send_byte(8'h84, ack);
      send_byte(8'h07, ack);
      chk("mid_ptr", 32'(rd_addr), 32'd7);
      send_bits(8'hA5, 4);
      m_sda = 1'b0;
      wcyc(Q);
      scl_hi();
      wcyc(Q);
      reset = 1'b1;
      wcyc(1);
      chk("mid_rst_sda", 32'(sda_oe),  32'd0);
      chk("mid_rst_scl", 32'(scl_oe),  32'd0);
      chk("mid_rst_busy", 32'(busy),   32'd0);
      chk("mid_rst_ptr", 32'(rd_addr), 32'd0);
      reset = 1'b0;
      wcyc(Q);
      m_sda = 1'b1;
      wcyc(Q);
      chk("mid_rst_no_wr", 32'(q_wa.size() - n0), 32'd0);
      chk("mid_rst_busy_end", 32'(busy), 32'd0);

      // STOP in the middle of the pointer byte
      i2c_start();
      send_byte(8'h84, ack);
      send_bits(8'hF5, 4);
      i2c_stop();
      wcyc(4);
      chk("stop_ptr_keep", 32'(rd_addr), 32'd0);
      chk("stop_ptr_busy", 32'(busy), 32'd0);

      // Normal traffic afterwards
      n0 = q_wa.size();
      i2c_start();
      send_byte(8'h84, ack); chk("post_addr_ack", 32'(ack), 32'd1);
      send_byte(8'h0A, ack);
      send_byte(8'h3C, ack); chk("post_data_ack", 32'(ack), 32'd1);
      i2c_stop();
      wcyc(4);
      chk("post_wr_count", 32'(q_wa.size() - n0), 32'd1);
      if (q_wa.size() >= n0 + 1) begin
         chk("post_wr_addr", 32'(q_wa[n0]), 32'h0A);
         chk("post_wr_data", 32'(q_wd[n0]), 32'h3C);
      end
      i2c_start();
      send_byte(8'h84, ack);
      send_byte(8'h0E, ack);
      i2c_start();
      send_byte(8'h85, ack);
      recv_byte(d, 1'b0);    chk("post_rd_byte", 32'(d), 32'h1E);
      i2c_stop();
      wcyc(4);

`ifdef I2C_CLOCK_STRETCH_EN
      chk("str_pulses_seen", 32'(str_q.size() > 0), 32'd1);
      for (int i = 0; i < str_q.size(); i++) chk("str_len", 32'(str_q[i]), 32'd4);
`else
      chk("scl_oe_never", 32'(str_q.size() + str_len), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
